// File: rtl/data_mem_responder.sv
// Memory-side responder for the data-memory port. It accepts one word request
// at a time, waits LATENCY cycles, then pulses a one-cycle response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready.
  // req_ready is high only in IDLE; inputs are ignored otherwise. resp_valid is a
  // one-cycle strobe with no backpressure; resp_rdata/resp_err hold between strobes.

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic               err_q;
  logic [IDX_W-1:0]   idx_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               req_err;
  logic [IDX_W-1:0]   req_idx;
  logic               entering_resp;
  logic               rsp_we;
  logic               rsp_err;
  logic [IDX_W-1:0]   rsp_idx;

  // Whole word index is range-checked, so high address bits never alias.
  assign req_err = (req_addr[1:0] != 2'b00) ||
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign req_idx = req_addr[IDX_W+1:2];
  assign accept  = rst && (state_q == ST_IDLE) && req_valid;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q  <= req_we;
        err_q <= req_err;
        idx_q <= req_idx;
        cnt_q <= CNT_INIT;
      end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dbg_state  = state_q;
    case (state_q)
      ST_IDLE: req_ready  = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // With LATENCY=0 the RESP entry edge is the acceptance edge, so use live inputs.
  assign entering_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign rsp_we  = (state_q == ST_IDLE) ? req_we  : we_q;
  assign rsp_err = (state_q == ST_IDLE) ? req_err : err_q;
  assign rsp_idx = (state_q == ST_IDLE) ? req_idx : idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else if (entering_resp) begin
      resp_err   <= rsp_err;
      resp_rdata <= (rsp_err || rsp_we) ? 32'h0 : mem[rsp_idx];
    end
  end

  // Storage is never cleared by reset; stores commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) mem[req_idx] <= req_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with LATENCY=2 and one with LATENCY=0,
// each checked by a scoreboard fed from a reference memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  // LATENCY=2 instance signals
  logic        rst_2, valid_2, we_2, ready_2, rv_2, err_2;
  logic [31:0] addr_2, wdata_2, rdata_2;
  logic [1:0]  st_2;
  // LATENCY=0 instance signals
  logic        rst_0, valid_0, we_0, ready_0, rv_0, err_0;
  logic [31:0] addr_0, wdata_0, rdata_0;
  logic [1:0]  st_0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst_2), .req_valid(valid_2), .req_we(we_2), .req_addr(addr_2),
    .req_wdata(wdata_2), .req_ready(ready_2), .resp_valid(rv_2), .resp_rdata(rdata_2),
    .resp_err(err_2), .dbg_state(st_2)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_l0 (
    .clk(clk), .rst(rst_0), .req_valid(valid_0), .req_we(we_0), .req_addr(addr_0),
    .req_wdata(wdata_0), .req_ready(ready_0), .resp_valid(rv_0), .resp_rdata(rdata_0),
    .resp_err(err_0), .dbg_state(st_0)
  );

  // Scoreboard: {err, rdata} and the cycle the strobe is due
  logic [32:0] exp_q2[$];
  logic [32:0] exp_q0[$];
  int          cyc_q2[$];
  int          cyc_q0[$];
  logic [31:0] mem2 [int];
  logic [31:0] mem0 [int];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input bit sel, input logic we,
                                        input logic [31:0] addr, input logic [31:0] wdata);
    int idx;
    idx = int'(addr[31:2]);
    if ((addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH))) return {1'b1, 32'h0};
    if (we) begin
      if (sel) mem2[idx] = wdata; else mem0[idx] = wdata;
      return {1'b0, 32'h0};
    end
    return {1'b0, (sel ? mem2[idx] : mem0[idx])};
  endfunction

  // Present a request and hold it until accepted; returns at the negedge after acceptance.
  task automatic drive(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit expect_resp, output int acc);
    int budget;
    bit done;
    logic [32:0] e;
    budget = 0;
    done   = 1'b0;
    acc    = -1;
    @(negedge clk);
    if (sel) begin valid_2 = 1'b1; we_2 = we; addr_2 = addr; wdata_2 = wdata; end
    else     begin valid_0 = 1'b1; we_0 = we; addr_0 = addr; wdata_0 = wdata; end
    while (!done && budget < 40) begin
      if ((sel ? ready_2 : ready_0) == 1'b1) done = 1'b1;
      else begin
        budget++;
        @(negedge clk);
      end
    end
    if (!done) begin
      check_val("accept_timeout", 64'(budget), 64'd0);
      return;
    end
    acc = cyc + 1;
    e = model(sel, we, addr, wdata);
    if (expect_resp) begin
      if (sel) begin exp_q2.push_back(e); cyc_q2.push_back(acc + 2); end
      else     begin exp_q0.push_back(e); cyc_q0.push_back(acc); end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit sel);
    if (sel) valid_2 = 1'b0; else valid_0 = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int b;
    b = 0;
    while (((sel ? exp_q2.size() : exp_q0.size()) != 0) && b < 50) begin
      b++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Response monitors
  logic [32:0] m2_e, m0_e;
  int          m2_c, m0_c;

  always @(negedge clk) begin
    if (rv_2 === 1'b1) begin
      if (exp_q2.size() == 0) check_val("unexpected_resp_l2", {err_2, rdata_2}, 64'h0);
      else begin
        m2_e = exp_q2.pop_front();
        m2_c = cyc_q2.pop_front();
        check_val("resp_l2", {err_2, rdata_2}, m2_e);
        check_val("latency_l2", 64'(cyc), 64'(m2_c));
        check_val("ready_in_resp_l2", ready_2, 1'b0);
      end
    end
    if (rv_0 === 1'b1) begin
      if (exp_q0.size() == 0) check_val("unexpected_resp_l0", {err_0, rdata_0}, 64'h0);
      else begin
        m0_e = exp_q0.pop_front();
        m0_c = cyc_q0.pop_front();
        check_val("resp_l0", {err_0, rdata_0}, m0_e);
        check_val("latency_l0", 64'(cyc), 64'(m0_c));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int prev;
    int idx;
    bit mis;
    logic we;
    logic [31:0] a;
    logic [31:0] d;

    rst_2 = 1'b0; valid_2 = 1'b0; we_2 = 1'b0; addr_2 = '0; wdata_2 = '0;
    rst_0 = 1'b0; valid_0 = 1'b0; we_0 = 1'b0; addr_0 = '0; wdata_0 = '0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", ready_2, 1'b1);
    check_val("rst_valid", rv_2, 1'b0);
    check_val("rst_rdata", rdata_2, 32'h0);
    check_val("rst_err", err_2, 1'b0);
    check_val("rst_state", st_2, 2'd0);
    check_val("rst_ready_l0", ready_0, 1'b1);
    rst_2 = 1'b1;
    rst_0 = 1'b1;

    // Store then check the ready-low window
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, acc);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      check_val("ready_low", ready_2, 1'b0);
      @(negedge clk);
    end
    check_val("ready_back", ready_2, 1'b1);

    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, acc);
    idle(1'b1);
    drain(1'b1);
    check_val("hold_rdata", rdata_2, 32'hDEADBEEF);
    check_val("hold_valid_low", rv_2, 1'b0);

    // Errors: misaligned store, out-of-range loads (including high address bits)
    drive(1'b1, 1'b1, 32'h12, 32'h1234, 1'b1, acc);
    idle(1'b1);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, acc);
    idle(1'b1);
    drive(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, acc);
    idle(1'b1);
    drive(1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b1, acc);
    idle(1'b1);
    drain(1'b1);

    // Valid held high, alternating store/load of the last word
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      d = $urandom | 32'h1;
      drive(1'b1, ((i % 2) == 0), 32'h3FC, d, 1'b1, acc);
      if (i > 0) check_val("b2b_spacing", 64'(acc - prev), 64'd4);
      prev = acc;
    end
    idle(1'b1);
    drain(1'b1);

    // Random mix over a few words
    for (int i = 0; i < 12; i++) begin
      idx = $urandom_range(0, 7);
      mis = ($urandom_range(0, 3) == 0);
      we  = 1'($urandom_range(0, 1));
      if (!mis && !mem2.exists(idx)) we = 1'b1;
      a = 32'(idx) << 2;
      if (mis) a = a | 32'($urandom_range(1, 3));
      drive(1'b1, we, a, $urandom, 1'b1, acc);
      idle(1'b1);
    end
    drive(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b1, acc);
    idle(1'b1);
    drain(1'b1);

    // Reset during WAIT drops the pending load
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, acc);
    idle(1'b1);
    #1 rst_2 = 1'b0;
    #1;
    check_val("midrst_ready", ready_2, 1'b1);
    check_val("midrst_valid", rv_2, 1'b0);
    check_val("midrst_rdata", rdata_2, 32'h0);
    check_val("midrst_err", err_2, 1'b0);
    check_val("midrst_state", st_2, 2'd0);
    @(negedge clk);
    rst_2 = 1'b1;
    repeat (8) @(negedge clk);
    drive(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b1, acc);
    idle(1'b1);
    drain(1'b1);

    // Zero-latency build: storage survives reset
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, acc);
    idle(1'b0);
    drain(1'b0);
    rst_0 = 1'b0;
    @(negedge clk);
    check_val("l0_rst_rdata", rdata_0, 32'h0);
    rst_0 = 1'b1;
    drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, acc);
    idle(1'b0);
    drive(1'b0, 1'b0, 32'h400, 32'h0, 1'b1, acc);
    idle(1'b0);
    drain(1'b0);

    check_val("q2_empty", 64'(exp_q2.size()), 64'd0);
    check_val("q0_empty", 64'(exp_q0.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
